mod_counter: RTL and testbench
==============================

// Module: mod_counter
// PURPOSE
//   Parametrised up/down modulo counter. Next generation of the 4-bit enable counter.
//   Adds configurable width, a runtime modulo limit, parallel load, and direction control.
//   Supports wrap, saturate and one-shot modes, a terminal-count pulse and a sticky overflow flag.
//   Used as the generic event/timer counter in datapath control blocks.
// PARAMETERS
//   WIDTH       8   counter width in bits (>=2)
//   RESET_VALUE 0   value of count after reset/clear (must be <= limit in use)
// PORTS
//   clk            in   1      rising-edge clock; single clock domain
//   reset_n        in   1      asynchronous, active-low reset
//   clear          in   1      synchronous clear to RESET_VALUE, exits DONE
//   enable         in   1      count one step this cycle
//   up_dn          in   1      1 = count up, 0 = count down
//   load           in   1      synchronous parallel load of load_value, exits DONE
//   load_value     in   WIDTH  value for load
//   limit          in   WIDTH  modulo limit; count range is 0..limit; sampled every cycle
//   mode           in   2      0 = WRAP, 1 = SATURATE, 2 = ONESHOT, 3 = reserved (acts as WRAP)
//   ovf_clr        in   1      clears the sticky overflow flag
//   count          out  WIDTH  current count (registered)
//   tc             out  1      terminal-count pulse, 1 cycle (registered)
//   overflow       out  1      sticky: boundary step has occurred since last clear
//   done           out  1      high while the FSM is in DONE (ONESHOT finished)
// BEHAVIOUR
// - Reset (reset_n=0, async): count=RESET_VALUE, tc=0, overflow=0, done=0, FSM=RUN.
// - Per-edge priority: clear > load > enable. Clear/load cycles do not count, pulse tc or set overflow.
// - FSM state RUN: an enabled step is normal or boundary.
//   * Normal up (count<limit): count+1. Normal down (count>0): count-1.
//   * Boundary up (count>=limit), or boundary down (count==0):
//       WRAP:     up -> 0, down -> limit.
//       SATURATE: count holds.
//       ONESHOT:  count holds; FSM -> DONE.
//     Every boundary step sets tc=1 for exactly the next cycle and sets overflow.
// - FSM state DONE: enable ignored, count holds, tc=0, done=1.
//   clear -> RUN with RESET_VALUE; load -> RUN with load_value; a mode change alone does not exit DONE.
// - tc=0 in every cycle without a boundary step. Back-to-back boundary steps (SATURATE or limit=0) keep tc=1 continuously.
// - overflow: set has priority over ovf_clr in the same cycle; clear also zeroes overflow.
// - Arithmetic is unsigned, modulo 2^WIDTH internally; never exceeds limit via counting.
// - load_value>limit is loaded as-is; the next up step is a boundary step.
// - limit may change at any time; comparison uses the current-cycle limit.
// - limit=0: every enabled step is a boundary step; count stays 0 (WRAP up/down gives 0).
// - Latency: count, tc, overflow and done all update on the edge after inputs are sampled.
// - Mid-operation reset_n assertion overrides everything immediately (async).
// TESTING
// 1 Reset: drive reset_n=0 mid-count -> count=RESET_VALUE, tc/overflow/done=0 immediately, before the next edge.
// 2 WRAP up: limit=5, up, enable for 7 cycles from 0 -> 1,2,3,4,5,0,1; tc high 1 cycle after the 5->0 edge; overflow=1.
// 3 WRAP down: limit=9, load 1, down, enable 3 cycles -> 0,9,8; tc pulses once.
// 4 SATURATE: limit=3, up, enable 6 cycles -> 1,2,3,3,3,3; tc stays high for 3 cycles; ovf_clr with a same-cycle set keeps overflow=1.
// 5 ONESHOT: limit=2, up -> 1,2, then done=1, count holds 2 while enable=1; load 7 -> RUN, count=7; next up step is a boundary step -> DONE again.
// 6 Priority: clear+load+enable in the same cycle -> count=RESET_VALUE, overflow=0; load+enable -> count=load_value, no step.

Source files
------------

// File: rtl/mod_counter.sv
// Up/down modulo counter with runtime limit, parallel load and direction control.
// Boundary behaviour is selectable: WRAP, SATURATE or ONESHOT (stops in DONE).
// Emits a one-cycle terminal-count pulse per boundary step and a sticky overflow flag.
module mod_counter #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    input  logic [1:0]       mode,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             overflow,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] MODE_SATURATE = 2'd1;
    localparam logic [1:0] MODE_ONESHOT  = 2'd2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state;
    logic             boundary;
    logic             holds_at_boundary;
    logic [WIDTH-1:0] step_value;

    // Value after one enabled step. A count loaded above the limit counts as
    // being at the top, so an up step from there is a boundary step.
    function automatic logic [WIDTH-1:0] next_count(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] lim,
        input logic             up,
        input logic             at_boundary,
        input logic             hold
    );
        logic [WIDTH-1:0] nxt;
        if (!at_boundary) begin
            nxt = up ? (cur + ONE) : (cur - ONE);
        end else if (hold) begin
            nxt = cur;
        end else begin
            nxt = up ? '0 : lim;
        end
        return nxt;
    endfunction

    // Classify the current step against the limit sampled this cycle.
    always_comb begin
        boundary          = up_dn ? (count >= limit) : (count == '0);
        holds_at_boundary = (mode == MODE_SATURATE) || (mode == MODE_ONESHOT);
        step_value        = next_count(count, limit, up_dn, boundary, holds_at_boundary);
    end

    // Counter, terminal-count pulse, sticky overflow and RUN/DONE state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= RESET_VALUE;
            tc       <= 1'b0;
            overflow <= 1'b0;
            state    <= ST_RUN;
        end else begin
            tc <= 1'b0;
            if (clear) begin
                count    <= RESET_VALUE;
                overflow <= 1'b0;
                state    <= ST_RUN;
            end else if (load) begin
                count <= load_value;
                state <= ST_RUN;
                if (ovf_clr) begin
                    overflow <= 1'b0;
                end
            end else if (enable && (state == ST_RUN)) begin
                count <= step_value;
                if (boundary) begin
                    // A boundary step sets overflow even if ovf_clr is high.
                    tc       <= 1'b1;
                    overflow <= 1'b1;
                    if (mode == MODE_ONESHOT) begin
                        state <= ST_DONE;
                    end
                end else if (ovf_clr) begin
                    overflow <= 1'b0;
                end
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: reset, wrap, saturate, one-shot,
// priority handling and limit=0 boundary behaviour.
module tb_mod_counter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             clear;
    logic             enable;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] limit;
    logic [1:0]       mode;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             overflow;
    logic             done;

    int total = 0;
    int bad   = 0;

    mod_counter #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(8'd0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .enable    (enable),
        .up_dn     (up_dn),
        .load      (load),
        .load_value(load_value),
        .limit     (limit),
        .mode      (mode),
        .ovf_clr   (ovf_clr),
        .count     (count),
        .tc        (tc),
        .overflow  (overflow),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] c, input logic t,
                           input logic o, input logic d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".tc"}, 32'(tc), 32'(t));
        chk({tag, ".overflow"}, 32'(overflow), 32'(o));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    logic [7:0] wrap_cnt [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    logic       wrap_tc  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] sat_cnt  [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
    logic       sat_tc   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        clear      = 1'b0;
        enable     = 1'b0;
        up_dn      = 1'b1;
        load       = 1'b0;
        load_value = '0;
        limit      = '0;
        mode       = 2'd0;
        ovf_clr    = 1'b0;

        // reset state
        #3;
        chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // WRAP up, limit 5
        limit  = 8'd5;
        mode   = 2'd0;
        up_dn  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("wrap_up%0d.count", i), 32'(count), 32'(wrap_cnt[i]));
            chk($sformatf("wrap_up%0d.tc", i), 32'(tc), 32'(wrap_tc[i]));
        end
        chk("wrap_up.overflow", 32'(overflow), 32'd1);

        // WRAP down, limit 9, load 1 while clearing overflow
        enable     = 1'b0;
        limit      = 8'd9;
        load       = 1'b1;
        load_value = 8'd1;
        ovf_clr    = 1'b1;
        tick();
        chk_all("wrap_dn_load", 8'd1, 1'b0, 1'b0, 1'b0);
        load    = 1'b0;
        ovf_clr = 1'b0;
        up_dn   = 1'b0;
        enable  = 1'b1;
        tick();
        chk_all("wrap_dn0", 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("wrap_dn1", 8'd9, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("wrap_dn2", 8'd8, 1'b0, 1'b1, 1'b0);

        // SATURATE, limit 3
        enable = 1'b0;
        clear  = 1'b1;
        tick();
        chk_all("sat_clear", 8'd0, 1'b0, 1'b0, 1'b0);
        clear  = 1'b0;
        mode   = 2'd1;
        limit  = 8'd3;
        up_dn  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) ovf_clr = 1'b1;
            tick();
            chk($sformatf("sat%0d.count", i), 32'(count), 32'(sat_cnt[i]));
            chk($sformatf("sat%0d.tc", i), 32'(tc), 32'(sat_tc[i]));
        end
        chk("sat_set_beats_clr.overflow", 32'(overflow), 32'd1);
        enable = 1'b0;
        tick();
        chk_all("sat_ovf_clr", 8'd3, 1'b0, 1'b0, 1'b0);
        ovf_clr = 1'b0;

        // ONESHOT, limit 2
        clear = 1'b1;
        tick();
        clear  = 1'b0;
        mode   = 2'd2;
        limit  = 8'd2;
        enable = 1'b1;
        tick();
        chk_all("os0", 8'd1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("os1", 8'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("os_boundary", 8'd2, 1'b1, 1'b1, 1'b1);
        tick();
        chk_all("os_hold", 8'd2, 1'b0, 1'b1, 1'b1);
        mode = 2'd0;
        tick();
        chk_all("os_mode_change", 8'd2, 1'b0, 1'b1, 1'b1);
        mode       = 2'd2;
        load       = 1'b1;
        load_value = 8'd7;
        tick();
        chk_all("os_load_exit", 8'd7, 1'b0, 1'b1, 1'b0);
        load = 1'b0;
        tick();
        chk_all("os_above_limit", 8'd7, 1'b1, 1'b1, 1'b1);

        // asynchronous reset mid-operation
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b0;

        // priority: clear > load > enable
        mode       = 2'd0;
        limit      = 8'd9;
        load       = 1'b1;
        load_value = 8'd9;
        tick();
        load   = 1'b0;
        enable = 1'b1;
        tick();
        chk_all("prio_setup", 8'd0, 1'b1, 1'b1, 1'b0);
        clear      = 1'b1;
        load       = 1'b1;
        load_value = 8'd5;
        tick();
        chk_all("prio_clear", 8'd0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        tick();
        chk_all("prio_load", 8'd5, 1'b0, 1'b0, 1'b0);

        // limit 0: every step is a boundary step, tc stays high
        load  = 1'b0;
        limit = 8'd0;
        tick();
        chk_all("lim0_up", 8'd0, 1'b1, 1'b1, 1'b0);
        up_dn = 1'b0;
        tick();
        chk_all("lim0_dn", 8'd0, 1'b1, 1'b1, 1'b0);
        enable = 1'b0;
        tick();
        chk_all("lim0_idle", 8'd0, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
